// File: rtl/rv_defs.sv
// Shared definitions for the uRV writeback path: load funct3 encodings and
// writeback FSM states.
package rv_defs;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rv_load_align.sv
// Combinational load lane extraction: selects byte/halfword/word from the
// memory read word and sign- or zero-extends it; valid=0 for unused funct3.
module rv_load_align
    import rv_defs::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] value,
    output logic        valid
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = data[7:0];
            2'd1:    lane_b = data[15:8];
            2'd2:    lane_b = data[23:16];
            default: lane_b = data[31:24];
        endcase
        lane_h = addr[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        value = 32'd0;
        valid = 1'b0;
        case (fun)
            LDST_B: begin
                value = {{24{lane_b[7]}}, lane_b};
                valid = 1'b1;
            end
            LDST_BU: begin
                value = {24'd0, lane_b};
                valid = 1'b1;
            end
            LDST_H: begin
                value = {{16{lane_h[15]}}, lane_h};
                valid = 1'b1;
            end
            LDST_HU: begin
                value = {16'd0, lane_h};
                valid = 1'b1;
            end
            LDST_L: begin
                value = data;
                valid = 1'b1;
            end
            default: begin
                value = 32'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// uRV writeback stage: commits ALU results and completes loads into the
// register file. Optional load timeout enabled by RV_WB_LOAD_TIMEOUT_EN.
module rv_writeback
    import rv_defs::*;
#(
    parameter int g_load_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic        w_stall_req_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_load_err_o
);

    wb_state_t   state, state_nxt;
    logic [4:0]  rd_p1;
    logic [2:0]  fun_p1;
    logic [1:0]  addr_p1;

    logic [2:0]  al_fun;
    logic [1:0]  al_addr;
    logic [31:0] al_value;
    logic        al_valid;

    logic        commit;
    logic        commit_wr;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        latch_load;
    logic        timeout;

    logic        unused_addr;
    assign unused_addr = ^x_dm_addr_i[31:2];

    // Pending load uses latched fields; otherwise align the live x_* inputs.
    assign al_fun  = (state == WB_WAIT_LOAD) ? fun_p1  : x_fun_i;
    assign al_addr = (state == WB_WAIT_LOAD) ? addr_p1 : x_dm_addr_i[1:0];

    rv_load_align u_align (
        .fun   (al_fun),
        .addr  (al_addr),
        .data  (dm_data_l_i),
        .value (al_value),
        .valid (al_valid)
    );

`ifdef RV_WB_LOAD_TIMEOUT_EN
    logic [7:0] cnt_p1;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_p1 + 8'd1;
    assign timeout = (state == WB_WAIT_LOAD) && !dm_load_done_i
                     && (cnt_inc == 8'(g_load_timeout));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_p1       <= 8'd0;
            w_load_err_o <= 1'b0;
        end else begin
            w_load_err_o <= timeout;
            if (latch_load)
                cnt_p1 <= 8'd0;
            else if (state == WB_WAIT_LOAD)
                cnt_p1 <= cnt_inc;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = ^8'(g_load_timeout);
    assign timeout      = 1'b0;
    assign w_load_err_o = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        w_stall_req_o = 1'b0;
        commit        = 1'b0;
        commit_wr     = 1'b0;
        commit_rd     = x_rd_i;
        commit_value  = x_rd_value_i;
        latch_load    = 1'b0;
        case (state)
            WB_IDLE: begin
                if (x_load_i) begin
                    if (dm_load_done_i) begin
                        commit       = 1'b1;
                        commit_value = al_value;
                        commit_wr    = al_valid && (x_rd_i != 5'd0);
                    end else begin
                        latch_load    = 1'b1;
                        w_stall_req_o = 1'b1;
                        state_nxt     = WB_WAIT_LOAD;
                    end
                end else begin
                    commit    = 1'b1;
                    commit_wr = x_rd_write_i && (x_rd_i != 5'd0);
                end
            end
            WB_WAIT_LOAD: begin
                commit_rd = rd_p1;
                if (dm_load_done_i) begin
                    commit       = 1'b1;
                    commit_value = al_value;
                    commit_wr    = al_valid && (rd_p1 != 5'd0);
                    state_nxt    = WB_IDLE;
                end else begin
                    w_stall_req_o = 1'b1;
                    if (timeout)
                        state_nxt = WB_IDLE;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Register-file write port boundary: all rf_* outputs registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= WB_IDLE;
            rd_p1         <= 5'd0;
            fun_p1        <= 3'd0;
            addr_p1       <= 2'd0;
            rf_rd_o       <= 5'd0;
            rf_rd_value_o <= 32'd0;
            rf_rd_write_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            rf_rd_write_o <= commit_wr;
            if (latch_load) begin
                rd_p1   <= x_rd_i;
                fun_p1  <= x_fun_i;
                addr_p1 <= x_dm_addr_i[1:0];
            end
            if (commit) begin
                rf_rd_o       <= commit_rd;
                rf_rd_value_o <= commit_value;
            end
        end
    end

endmodule
